// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU frame controller: opcodes, opcode check, FSM states.
package uart_alu_pkg;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_B,
    ST_WAIT_OP,
    ST_EXEC,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

  function automatic logic is_valid_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_valid_op = 1'b1;
      default:                        is_valid_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte tick counter; o_expire holds once TIMEOUT_TICKS ticks have been seen while enabled.
// Only built with UART_ALU_TIMEOUT_EN.
`ifdef UART_ALU_TIMEOUT_EN
module frame_timeout #(
  parameter int TIMEOUT_TICKS = 640,
  localparam int NB_CNT = $clog2(TIMEOUT_TICKS + 1)
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  logic [NB_CNT-1:0] r_cnt;
  logic              w_full;

  assign w_full   = (r_cnt == NB_CNT'(TIMEOUT_TICKS));
  assign o_expire = i_en && w_full;

  // Clear beats a coincident tick, so a received byte always restarts the wait.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && i_tick && !w_full) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/uart_alu_ctrl.sv
// Collects A, B, opcode bytes from uart_rx, drives the ALU, and hands the result to uart_tx.
// Optional inter-byte timeout enabled by defining UART_ALU_TIMEOUT_EN.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA       = 8,
  parameter int NB_OP         = 6,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_error
);

  state_t             r_state;
  logic [NB_DATA-1:0] r_alu_a;
  logic [NB_DATA-1:0] r_alu_b;
  logic [NB_OP-1:0]   r_alu_op;
  logic [NB_DATA-1:0] r_tx_data;
  logic               r_tx_start;
  logic               r_busy;
  logic               r_error;
  logic               w_timeout;
  logic               w_op_valid;

  assign w_op_valid = is_valid_op(i_rx_data[NB_OP-1:0]);

`ifdef UART_ALU_TIMEOUT_EN
  logic w_waiting;

  assign w_waiting = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);

  frame_timeout #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_frame_timeout (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_tick   (i_tick),
    .i_en     (w_waiting),
    .i_clr    (i_rx_done || !w_waiting),
    .o_expire (w_timeout)
  );
`else
  localparam int unused_timeout_ticks = TIMEOUT_TICKS;
  logic w_unused_tick;

  assign w_unused_tick = i_tick;
  assign w_timeout     = 1'b0;
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_error    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_rx_done) begin
            r_alu_a <= i_rx_data;
            r_busy  <= 1'b1;
            r_state <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (i_rx_done) begin
            r_alu_b <= i_rx_data;
            r_state <= ST_WAIT_OP;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT_OP: begin
          if (i_rx_done && w_op_valid) begin
            r_alu_op <= i_rx_data[NB_OP-1:0];
            r_state  <= ST_EXEC;
          end else if (i_rx_done || w_timeout) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          r_tx_data  <= i_alu_result;
          r_tx_start <= 1'b1;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          r_state <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          // Any byte arriving here, even together with tx_done, is dropped.
          if (i_tx_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_busy     = r_busy;
  assign o_error    = r_error;

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Frame controller between `uart_rx`, the ALU and `uart_tx`. It collects a three-byte command frame from the receiver: operand A, then operand B, then opcode. It drives the ALU with registered operands, captures the result, and hands it to the transmitter with a start/done handshake. It is the only sequencing logic between the UART pair and the ALU in the top level.

## Interface
Parameters:
- `NB_DATA`, 8, data, operand and result width.
- `NB_OP`, 6, ALU opcode width (low bits of the opcode byte).
- `TIMEOUT_TICKS`, 640, inter-byte timeout in `i_tick` pulses (≈4 frames at 16 ticks/bit); used only with `UART_ALU_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock; one clock domain.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_tick` in 1: baud-rate generator tick, 1-cycle pulse.
- `i_rx_data` in NB_DATA: received byte; valid when `i_rx_done`=1.
- `i_rx_done` in 1: 1-cycle pulse from `uart_rx`.
- `i_alu_result` in NB_DATA: combinational ALU result.
- `i_tx_done` in 1: 1-cycle pulse from `uart_tx` at end of its stop bit.
- `o_alu_a`, `o_alu_b` out NB_DATA: registered operands.
- `o_alu_op` out NB_OP: registered opcode.
- `o_tx_data` out NB_DATA: result byte to transmit.
- `o_tx_start` out 1: 1-cycle transmit request.
- `o_busy` out 1: high in every state except IDLE.
- `o_error` out 1: 1-cycle pulse on invalid opcode or timeout.

## Operation
- States: IDLE → WAIT_B → WAIT_OP → EXEC → SEND → WAIT_TX → IDLE.
- IDLE: on `i_rx_done`, latch `i_rx_data` into A and go to WAIT_B.
- WAIT_B: on `i_rx_done`, latch into B and go to WAIT_OP.
- WAIT_OP: on `i_rx_done`, check `i_rx_data[NB_OP-1:0]` against the valid set (ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRA 0x03, SRL 0x02).
  - Valid: latch `o_alu_op` and go to EXEC.
  - Invalid: pulse `o_error`, return to IDLE. A, B and op registers are unchanged.
- `o_alu_a` and `o_alu_b` update at latch time, so operands settle before EXEC.
- EXEC: single cycle; register `i_alu_result` into `o_tx_data`; go to SEND.
- SEND: `o_tx_start`=1 for exactly this cycle; go to WAIT_TX.
- WAIT_TX: on `i_tx_done`, go to IDLE.
- `i_rx_done` in EXEC, SEND or WAIT_TX is ignored: byte dropped, no error.
- `i_rx_done` and `i_tx_done` in the same WAIT_TX cycle: go to IDLE and drop the byte.
- Opcode byte bits above NB_OP are ignored.

## Timing
- Reset values: state IDLE; all outputs 0.
- Reset takes effect asynchronously, including mid-frame and mid-transmit; the partial frame is discarded.
- `i_rx_done` on the opcode byte in cycle N:
  - EXEC in cycle N+1 (`o_alu_op` valid from N+1).
  - `o_tx_start` high in N+2, with `o_tx_data` already valid.
- `o_tx_data` holds its value until the next EXEC.
- `o_error` asserts in the cycle after the triggering event and lasts 1 cycle.
- `o_busy` rises the cycle after the first byte is accepted and falls the cycle after `i_tx_done` (or after an error).

## Configuration
- Macro: `UART_ALU_TIMEOUT_EN`.
- Defined:
  - In WAIT_B and WAIT_OP, count `i_tick` pulses; the count clears on `i_rx_done` and on entering IDLE.
  - When the count reaches `TIMEOUT_TICKS`, pulse `o_error` and return to IDLE.
  - `i_tick` coincident with `i_rx_done`: the byte wins and the count clears.
  - Counter width is `$clog2(TIMEOUT_TICKS+1)`.
- Undefined: no counter; WAIT_B and WAIT_OP wait indefinitely; `i_tick` is unconnected internally.

## Structure
- Package `uart_alu_pkg`: opcode localparams, valid-opcode function, state enum.
- Sub-module `frame_timeout`: tick counter with clear/enable/expire. Instantiated only under `UART_ALU_TIMEOUT_EN`.

## Test plan
- Frame 0x05, 0x03, 0x20 with ALU model → `o_tx_start` at N+2, `o_tx_data`=0x08; `o_busy` clears after `i_tx_done`.
- Frame 0x0F, 0xF0, 0x26 then 0x80, 0x02, 0x03 back-to-back → results 0xFF then 0xE0, two `o_tx_start` pulses.
- Frame 0x01, 0x02, 0x3F (invalid) → one `o_error` pulse, no `o_tx_start`, state IDLE.
- Byte injected during WAIT_TX, simultaneous with `i_tx_done` → ignored; the next three bytes form a correct frame.
- `UART_ALU_TIMEOUT_EN`, TIMEOUT_TICKS=32: send 0x11 then 32 ticks with no byte → `o_error`; a following full frame 0x02, 0x02, 0x22 gives 0x00.
- Assert `i_rst_n`=0 in WAIT_OP and in WAIT_TX → all outputs 0 immediately; a fresh frame after release works.
